timer_counter16: RTL and testbench
==================================

// Module: timer_counter16
// PURPOSE
//  16-bit timer/counter core clocked by the system clock, advanced only by the prescaler's
//  single-cycle rising-edge strobe (i_cnt_tick). Sits directly downstream of the prescaler.
//  Provides up/down counting, auto-reload or one-shot operation, compare match, overflow
//  pulses and a sticky interrupt flag. Host writes go through a 2-bit-address register port.
// PARAMETERS
//  CNT_W   16   counter, reload and compare width
// PORTS
//  i_sysclk      in   1      system clock, single clock domain
//  i_sysrst      in   1      synchronous, active-high reset
//  i_module_en   in   1      module enable; also drives the prescaler enable
//  i_cnt_tick    in   1      count strobe (prescaler o_sclk_rise), 1 cycle wide
//  i_start       in   1      start pulse
//  i_stop        in   1      stop pulse
//  i_wr          in   1      register write strobe
//  i_addr        in   2      0=CTRL 1=RELOAD 2=CMP 3=COUNT
//  i_wdata       in   CNT_W  write data
//  i_irq_clr     in   1      clear sticky irq
//  o_cnt         out  CNT_W  current count (registered)
//  o_busy        out  1      high in RUN
//  o_ovf         out  1      terminal-count pulse, 1 cycle
//  o_cmp         out  1      compare-match pulse, 1 cycle
//  o_irq         out  1      sticky interrupt
// BEHAVIOUR
//  - Reset: all registers 0, FSM=IDLE, all outputs 0.
//  - CTRL: bit0 DIR (0=up, 1=down), bit1 ONESHOT, bit2 IRQ_EN. Other bits ignored.
//  - Start value: up=0, down=RELOAD. Terminal value: up=RELOAD, down=0.
//  - FSM IDLE: count held. i_start -> RUN, cnt<=start value (next cycle).
//  - FSM RUN: on a tick with cnt!=terminal, count +1 (up) or -1 (down).
//  - RUN, tick with cnt==terminal: o_ovf=1 that same cycle (combinational on registered
//    state, like the prescaler strobes).
//    * Continuous mode: cnt<=start value.
//    * ONESHOT: -> DONE and cnt holds the terminal value.
//  - FSM DONE: count held, o_busy=0. i_start -> RUN with reload of the start value.
//  - i_stop in RUN -> IDLE, count held.
//  - Same-cycle priority: i_stop > i_start > tick. A tick coinciding with stop or start is
//    ignored.
//  - o_cmp=1 when RUN & tick & cnt==CMP (value before update). May coincide with o_ovf.
//  - o_cnt changes one cycle after the tick/start cycle.
//  - No intermediate width growth: +1/-1 wraps modulo 2^CNT_W only via the terminal reload.
//  - RELOAD=0, up mode: terminal is hit on every tick; o_ovf asserts every tick.
//  - Register write takes effect the next cycle.
//  - Write to COUNT: overrides any tick/start update of cnt in that cycle, in any state.
//  - Write to RELOAD/CMP during RUN: used from the next cycle. No shadowing.
//  - o_irq: set when IRQ_EN & (o_ovf | o_cmp); cleared by i_irq_clr. Set wins over a
//    simultaneous clear.
//  - i_module_en=0: FSM forced to IDLE and o_ovf/o_cmp gated to 0. Count, registers and
//    irq are held; writes are still accepted.
//  - Reset mid-RUN: returns to the reset state next cycle; no pulse is emitted.
// STRUCTURE
//  - Shared include timer_counter_defs.vh: address localparams (ADDR_CTRL/RELOAD/CMP/COUNT),
//    CTRL bit indices, FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//  - One sub-module, timer_counter_regs: CTRL/RELOAD/CMP write decode and storage.
//  - FSM, counter datapath and irq logic stay in the top level.
// TESTING
//  - Up, continuous: RELOAD=3, start, 8 ticks -> o_cnt 1,2,3,0,1,2,3,0; o_ovf on ticks 4 and 8.
//  - Down, one-shot: RELOAD=2, start, 4 ticks -> o_cnt 2,1,0 then DONE; o_ovf once;
//    o_busy=0; 4th tick ignored.
//  - Compare + irq: CMP=5, IRQ_EN=1, up RELOAD=9 -> o_cmp on the tick seen at cnt=5; o_irq
//    sticks; i_irq_clr alone clears it; clear coinciding with a new match keeps it set.
//  - Priority: stop+start+tick in the same cycle -> IDLE, count unchanged. COUNT write plus
//    tick -> written value.
//  - Enable/reset: drop i_module_en mid-RUN -> IDLE, no pulses. i_sysrst mid-RUN -> all
//    outputs 0 next cycle.
//  - Edge case: RELOAD=0, up -> o_ovf on every tick and o_cnt stays 0.

Source files
------------

// File: rtl/timer_counter16_pkg.sv
// Shared definitions for the 16-bit timer/counter: register map, CTRL bit layout and FSM states.
package timer_counter16_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RELOAD = 2'd1;
    localparam logic [1:0] ADDR_CMP    = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_DIR     = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic dir;
    } ctrl_t;

endpackage

// File: rtl/timer_counter16_if.sv
// Host register write port of the timer: strobe, 2-bit address and write data.
interface timer_counter16_if;
    import timer_counter16_pkg::*;

    logic             wr;
    logic [1:0]       addr;
    logic [CNT_W-1:0] wdata;

    modport master (output wr, addr, wdata);
    modport slave  (input  wr, addr, wdata);
endinterface

// File: rtl/timer_counter16_regs.sv
// CTRL/RELOAD/CMP storage; the COUNT address is handled by the counter datapath in the top.
module timer_counter16_regs
    import timer_counter16_pkg::*;
(
    input  logic                 i_sysclk,
    input  logic                 i_sysrst,
    timer_counter16_if.slave     reg_if,
    output ctrl_t                o_ctrl,
    output logic [CNT_W-1:0]     o_reload,
    output logic [CNT_W-1:0]     o_cmp_val
);

    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] cmp_q;

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            ctrl_q   <= '0;
            reload_q <= '0;
            cmp_q    <= '0;
        end else if (reg_if.wr) begin
            case (reg_if.addr)
                ADDR_CTRL: begin
                    ctrl_q.dir     <= reg_if.wdata[CTRL_DIR];
                    ctrl_q.oneshot <= reg_if.wdata[CTRL_ONESHOT];
                    ctrl_q.irq_en  <= reg_if.wdata[CTRL_IRQ_EN];
                end
                ADDR_RELOAD: reload_q <= reg_if.wdata;
                ADDR_CMP:    cmp_q    <= reg_if.wdata;
                default:     ;
            endcase
        end
    end

    assign o_ctrl    = ctrl_q;
    assign o_reload  = reload_q;
    assign o_cmp_val = cmp_q;

endmodule

// File: rtl/timer_counter16.sv
// 16-bit up/down timer/counter advanced by a prescaler strobe, with one-shot, compare and sticky irq.
module timer_counter16
    import timer_counter16_pkg::*;
(
    input  logic                 i_sysclk,
    input  logic                 i_sysrst,
    input  logic                 i_module_en,
    input  logic                 i_cnt_tick,
    input  logic                 i_start,
    input  logic                 i_stop,
    timer_counter16_if.slave     reg_if,
    input  logic                 i_irq_clr,
    output logic [CNT_W-1:0]     o_cnt,
    output logic                 o_busy,
    output logic                 o_ovf,
    output logic                 o_cmp,
    output logic                 o_irq
);

    ctrl_t            ctrl;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] cmp_val;

    timer_counter16_regs u_regs (
        .i_sysclk  (i_sysclk),
        .i_sysrst  (i_sysrst),
        .reg_if    (reg_if),
        .o_ctrl    (ctrl),
        .o_reload  (reload),
        .o_cmp_val (cmp_val)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] term_val;
    logic             at_term;
    logic             cnt_wr;
    logic             tick_run;
    logic             ovf_pulse;
    logic             cmp_pulse;

    assign start_val = ctrl.dir ? reload : '0;
    assign term_val  = ctrl.dir ? '0 : reload;
    assign at_term   = (cnt_q == term_val);
    assign cnt_wr    = reg_if.wr && (reg_if.addr == ADDR_COUNT);

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        tick_run = 1'b0;

        // Stop beats start beats tick; a disabled module parks in IDLE with everything held.
        if (!i_module_en) begin
            state_d = ST_IDLE;
        end else if (i_stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (i_start) begin
            state_d = ST_RUN;
            cnt_d   = start_val;
        end else if ((state_q == ST_RUN) && i_cnt_tick) begin
            tick_run = 1'b1;
            if (at_term) begin
                if (ctrl.oneshot) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = start_val;
                end
            end else begin
                cnt_d = ctrl.dir ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
            end
        end

        if (cnt_wr) begin
            cnt_d = reg_if.wdata;
        end

        ovf_pulse = tick_run && at_term && !i_sysrst;
        cmp_pulse = tick_run && (cnt_q == cmp_val) && !i_sysrst;

        if (ctrl.irq_en && (ovf_pulse || cmp_pulse)) begin
            irq_d = 1'b1;
        end else if (i_irq_clr && i_module_en) begin
            irq_d = 1'b0;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_busy = (state_q == ST_RUN);
    assign o_ovf  = ovf_pulse;
    assign o_cmp  = cmp_pulse;
    assign o_irq  = irq_q;

endmodule

// File: tb/tb_timer_counter16.sv
// Directed bench for timer_counter16: counting modes, compare/irq, priority, enable and reset.
module tb_timer_counter16;
    import timer_counter16_pkg::*;

    logic             clk = 1'b0;
    logic             srst;
    logic             en;
    logic             tick;
    logic             start;
    logic             stop;
    logic             irq_clr;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ovf;
    logic             cmp;
    logic             irq;

    logic             ovf_s;
    logic             cmp_s;
    int               n_chk  = 0;
    int               n_pass = 0;

    timer_counter16_if bus ();

    timer_counter16 dut (
        .i_sysclk    (clk),
        .i_sysrst    (srst),
        .i_module_en (en),
        .i_cnt_tick  (tick),
        .i_start     (start),
        .i_stop      (stop),
        .reg_if      (bus),
        .i_irq_clr   (irq_clr),
        .o_cnt       (cnt),
        .o_busy      (busy),
        .o_ovf       (ovf),
        .o_cmp       (cmp),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("  ok   %-14s = %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse outputs are sampled mid-cycle before the edge; registered outputs just after it.
    task automatic step();
        #2;
        ovf_s = ovf;
        cmp_s = cmp;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        irq_clr = 1'b0;
        bus.wr  = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [CNT_W-1:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        step();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
    endtask

    initial begin
        srst = 1'b1; en = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        step();
        step();
        srst = 1'b0;
        check("rst_cnt", cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_cmp", cmp_s, 0);

        // Up, continuous, RELOAD=3
        en = 1'b1;
        wr_reg(ADDR_RELOAD, 16'd3);
        start = 1'b1; step();
        check("up_start_cnt", cnt, 0);
        check("up_busy", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check($sformatf("up_cnt%0d", k), cnt, k % 4);
            check($sformatf("up_ovf%0d", k), ovf_s, (k % 4 == 0));
            check($sformatf("up_cmp%0d", k), cmp_s, (k % 4 == 1));
        end

        // Down, one-shot, RELOAD=2
        stop = 1'b1; step();
        check("stop_busy", busy, 0);
        wr_reg(ADDR_CTRL, 16'h0003);
        wr_reg(ADDR_RELOAD, 16'd2);
        start = 1'b1; step();
        check("dn_start_cnt", cnt, 2);
        do_tick(); check("dn_cnt1", cnt, 1); check("dn_ovf1", ovf_s, 0);
        do_tick(); check("dn_cnt2", cnt, 0); check("dn_ovf2", ovf_s, 0);
        do_tick(); check("dn_cnt3", cnt, 0); check("dn_ovf3", ovf_s, 1);
        check("dn_done_busy", busy, 0);
        do_tick(); check("dn_cnt4", cnt, 0); check("dn_ovf4", ovf_s, 0);

        // Compare + irq: up continuous, IRQ_EN, RELOAD=9, CMP=5
        wr_reg(ADDR_CTRL, 16'h0004);
        wr_reg(ADDR_RELOAD, 16'd9);
        wr_reg(ADDR_CMP, 16'd5);
        start = 1'b1; step();
        for (int k = 0; k < 5; k++) do_tick();
        check("cmp_pre_cnt", cnt, 5);
        check("cmp_pre_irq", irq, 0);
        do_tick();
        check("cmp_hit", cmp_s, 1);
        check("cmp_cnt6", cnt, 6);
        check("cmp_irq_set", irq, 1);
        irq_clr = 1'b1; step();
        check("irq_clr", irq, 0);
        for (int k = 0; k < 3; k++) do_tick();
        check("cmp_cnt9", cnt, 9);
        do_tick();
        check("ovf9", ovf_s, 1);
        check("ovf9_cnt", cnt, 0);
        check("ovf_irq", irq, 1);
        irq_clr = 1'b1; step();
        check("irq_clr2", irq, 0);
        for (int k = 0; k < 5; k++) do_tick();
        tick = 1'b1; irq_clr = 1'b1; step();
        check("clr_vs_set_cmp", cmp_s, 1);
        check("clr_vs_set_irq", irq, 1);

        // Priority
        stop = 1'b1; start = 1'b1; tick = 1'b1; step();
        check("prio_busy", busy, 0);
        check("prio_cnt", cnt, 6);
        check("prio_cmp", cmp_s, 0);
        start = 1'b1; step();
        check("restart_cnt", cnt, 0);
        tick = 1'b1;
        wr_reg(ADDR_COUNT, 16'd7);
        check("wr_vs_tick", cnt, 7);

        // Enable drop mid-RUN with cnt at CMP
        wr_reg(ADDR_COUNT, 16'd5);
        en = 1'b0; tick = 1'b1; step();
        check("dis_cmp", cmp_s, 0);
        check("dis_busy", busy, 0);
        check("dis_cnt", cnt, 5);
        check("dis_irq_held", irq, 1);
        wr_reg(ADDR_COUNT, 16'd9);
        check("dis_wr_cnt", cnt, 9);
        en = 1'b1;
        do_tick();
        check("idle_tick_cnt", cnt, 9);

        // Reset mid-RUN at terminal count
        start = 1'b1; step();
        wr_reg(ADDR_COUNT, 16'd9);
        srst = 1'b1; tick = 1'b1; step();
        check("rst_run_ovf", ovf_s, 0);
        check("rst_run_cnt", cnt, 0);
        check("rst_run_busy", busy, 0);
        check("rst_run_irq", irq, 0);
        srst = 1'b0;

        // RELOAD=0, up: terminal every tick
        start = 1'b1; step();
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check($sformatf("r0_ovf%0d", k), ovf_s, 1);
            check($sformatf("r0_cnt%0d", k), cnt, 0);
        end
        check("r0_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
